// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_RECOVER
  } uart_rx_state_t;

  localparam int UART_DIV_MIN = 4;
  localparam int UART_DATA_W  = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Single-clock receive FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [AW:0]  count,
  output logic         drop
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          pop_en;
  logic          wr_en;

  assign full   = (count == (AW+1)'(DEPTH));
  assign pop_en = pop && (count != '0);
  assign wr_en  = push && (!full || pop_en);
  assign drop   = push && !wr_en;
  assign dout   = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en)  wptr <= wptr + 1'b1;
      if (pop_en) rptr <= rptr + 1'b1;
      unique case ({wr_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver: synchronizer, oversampling deframer and
// a receive FIFO behind a valid/ready port.
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DIV_W-1:0]       cfg_divisor,
  input  logic                   ser_rx,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   rx_frame_err,
  output logic                   rx_overrun,
  output logic [$clog2(DEPTH):0] rx_count
);

  uart_rx_state_t        state;
  logic                  sync_q;
  logic                  rx_s;
  logic [DIV_W-1:0]      cnt;
  logic [DIV_W-1:0]      div_q;
  logic [DIV_W-1:0]      div_eff;
  logic [2:0]            bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                  push_q;
  logic                  bit_end;
  logic                  half_end;
  logic                  pop;

  assign div_eff  = (cfg_divisor < DIV_W'(UART_DIV_MIN))
                  ? DIV_W'(UART_DIV_MIN) : cfg_divisor;
  assign bit_end  = (cnt == div_q - 1'b1);
  assign half_end = (cnt == (div_q >> 1) - 1'b1);

  // Both flops reset high so a low line is not taken as a start bit
  // until it has first been seen idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_q <= ser_rx;
      rx_s   <= sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      div_q        <= DIV_W'(UART_DIV_MIN);
      bit_idx      <= '0;
      shreg        <= '0;
      push_q       <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      rx_frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
            div_q <= div_eff;
          end
        end
        ST_START: begin
          if (half_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (rx_s) begin
              push_q <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= ST_RECOVER;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rx_valid = (rx_count != '0);
  assign pop      = rx_valid && rx_ready;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_q),
    .pop    (pop),
    .din    (shreg),
    .dout   (rx_data),
    .count  (rx_count),
    .drop   (rx_overrun)
  );

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: vector table, scoreboard
// and hand-written corner-case sequences.
module tb_uart_rx_buf;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] cfg_divisor;
  logic        ser_rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_frame_err;
  logic        rx_overrun;
  logic [3:0]  rx_count;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ov_cnt   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_buf #(.DEPTH(8), .DIV_W(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .cfg_divisor  (cfg_divisor),
    .ser_rx       (ser_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .rx_count     (rx_count)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       stop;
    logic       exp_push;
    int         exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (resetn) begin
      if (rx_frame_err) ferr_cnt++;
      if (rx_overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got %0h want none", rx_data);
        end else begin
          check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input int div,
                            input logic stop);
    int p;
    p = (div < 4) ? 4 : div;
    cfg_divisor = 16'(div);
    ser_rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (p) @(negedge clk);
    end
    ser_rx = stop;
    repeat (p) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while ((rx_count != 0 || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_count"}, 32'(rx_count), 0);
    check({name, "_sb"}, exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   f0;
    int   o0;
    int   lat;

    vecs[0] = '{8'hA5, 16, 1'b1, 1'b1, 0};
    vecs[1] = '{8'h81,  2, 1'b1, 1'b1, 0};
    vecs[2] = '{8'h00,  4, 1'b1, 1'b1, 0};
    vecs[3] = '{8'hFF,  7, 1'b1, 1'b1, 0};
    vecs[4] = '{8'h3C, 16, 1'b0, 1'b0, 1};
    vecs[5] = '{8'h5A,  5, 1'b1, 1'b1, 0};

    resetn      = 1'b0;
    ser_rx      = 1'b1;
    rx_ready    = 1'b0;
    cfg_divisor = 16'd16;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(rx_valid), 0);
    check("rst_count", 32'(rx_count), 0);
    check("rst_ferr", 32'(rx_frame_err), 0);
    check("rst_ovr", 32'(rx_overrun), 0);

    // START entry trails the line edge by 3 cycles (2 sync + IDLE)
    fork
      send_frame(8'hA5, 16, 1'b1);
      begin
        lat = 0;
        while (!rx_valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("lat_cycles", lat, 153 + 3);
    check("lat_data", 32'(rx_data), 32'hA5);
    check("lat_count", 32'(rx_count), 1);
    exp_q.push_back(8'hA5);
    rx_ready = 1'b1;
    wait_empty("basic");

    foreach (vecs[i]) begin
      f0 = ferr_cnt;
      if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].div, vecs[i].stop);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
    end
    wait_empty("table");

    f0 = ferr_cnt;
    cfg_divisor = 16'd16;
    ser_rx = 1'b0;
    repeat (5) @(negedge clk);
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("false_valid", 32'(rx_valid), 0);
    check("false_count", 32'(rx_count), 0);
    check("false_ferr", ferr_cnt - f0, 0);

    f0 = ferr_cnt;
    send_frame(8'h3C, 16, 1'b0);
    ser_rx = 1'b0;
    repeat (640) @(negedge clk);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_count", 32'(rx_count), 0);
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 16, 1'b1);
    repeat (4) @(negedge clk);
    wait_empty("recover");
    check("recover_ferr", ferr_cnt - f0, 1);

    rx_ready = 1'b0;
    o0 = ov_cnt;
    for (int b = 0; b < 9; b++) begin
      if (b < 8) exp_q.push_back(8'(b));
      send_frame(8'(b), 4, 1'b1);
    end
    repeat (10) @(negedge clk);
    check("ovr_count", 32'(rx_count), 8);
    check("ovr_pulses", ov_cnt - o0, 1);
    rx_ready = 1'b1;
    wait_empty("ovr_drain");

    rx_ready = 1'b0;
    o0 = ov_cnt;
    for (int b = 16; b < 24; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 4, 1'b1);
    end
    exp_q.push_back(8'h18);
    // push cycle of a div-4 frame is 41 cycles after the start edge
    fork
      send_frame(8'h18, 4, 1'b1);
      begin
        repeat (41) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("popfull_count", 32'(rx_count), 8);
    check("popfull_ovr", ov_cnt - o0, 0);
    rx_ready = 1'b1;
    wait_empty("popfull_drain");

    f0 = ferr_cnt;
    exp_q.push_back(8'h5A);
    fork
      send_frame(8'h5A, 16, 1'b1);
      begin
        repeat (50) @(negedge clk);
        cfg_divisor = 16'd32;
      end
    join
    repeat (4) @(negedge clk);
    wait_empty("divchg");
    check("divchg_ferr", ferr_cnt - f0, 0);

    rx_ready = 1'b0;
    f0 = ferr_cnt;
    send_frame(8'h77, 16, 1'b1);
    repeat (4) @(negedge clk);
    check("prerst_count", 32'(rx_count), 1);
    ser_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ser_rx = i[0];
      repeat (16) @(negedge clk);
    end
    ser_rx = 1'b0;
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    ser_rx = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    check("midrst_valid", 32'(rx_valid), 0);
    check("midrst_count", 32'(rx_count), 0);
    check("midrst_ferr", 32'(rx_frame_err), 0);
    check("midrst_ovr", 32'(rx_overrun), 0);
    repeat (40) @(negedge clk);
    check("midrst_idle_count", 32'(rx_count), 0);
    rx_ready = 1'b1;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 16, 1'b1);
    repeat (4) @(negedge clk);
    wait_empty("midrst_next");
    check("midrst_ferr_total", ferr_cnt - f0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
